// File: rtl/gb_lcd_capture.sv
// gb_lcd_capture: filters the Game Boy LCD bus, recovers pixel position and emits one framebuffer write per pixel.
// Optional feature macro GB_CAPTURE_SYNC_EN: 2-flop synchronizer on all raw inputs (+2 cycles latency).
module gb_lcd_capture #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned DATA_DELAY = 5,
  parameter int unsigned H_PIXELS   = 160,
  parameter int unsigned V_LINES    = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  idata,
  input  logic        ihsync,
  input  logic        ivsync,
  input  logic        iclk,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [1:0]  wr_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_err
);

  localparam int unsigned HW = FILTER_LEN - 1;
  localparam int unsigned AW = 15;
  localparam logic [7:0] H_MAX = 8'(H_PIXELS);
  localparam logic [7:0] V_MAX = 8'(V_LINES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(H_PIXELS * V_LINES - 1);

  logic [1:0] s_data;
  logic       s_hs, s_vs, s_clk;

`ifdef GB_CAPTURE_SYNC_EN
  // Order {data[1:0], hsync, vsync, pixel clock}; reset to the idle bus levels.
  logic [4:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 5'b00100;
      sync2 <= 5'b00100;
    end else begin
      sync1 <= {idata, ihsync, ivsync, iclk};
      sync2 <= sync1;
    end
  end
  assign {s_data, s_hs, s_vs, s_clk} = sync2;
`else
  assign {s_data, s_hs, s_vs, s_clk} = {idata, ihsync, ivsync, iclk};
`endif

  logic [HW-1:0] h_clk, h_hs, h_vs;
  logic          f_clk, f_hs, f_vs;
  logic [1:0]    dhist [DATA_DELAY];
  logic          clk_fall, clk_rise, hs_fall, hs_rise, vs_fall, vs_rise;

  // An edge fires when the current sample and the FILTER_LEN-1 before it all disagree with the filtered state.
  assign clk_fall = f_clk  && ({h_clk, s_clk} == '0);
  assign clk_rise = !f_clk && (&{h_clk, s_clk});
  assign hs_fall  = f_hs   && ({h_hs, s_hs} == '0);
  assign hs_rise  = !f_hs  && (&{h_hs, s_hs});
  assign vs_fall  = f_vs   && ({h_vs, s_vs} == '0);
  assign vs_rise  = !f_vs  && (&{h_vs, s_vs});

  always_ff @(posedge clk) begin
    if (rst) begin
      h_clk <= '0;
      h_hs  <= '1;
      h_vs  <= '0;
      f_clk <= 1'b0;
      f_hs  <= 1'b1;
      f_vs  <= 1'b0;
      for (int i = 0; i < int'(DATA_DELAY); i++) dhist[i] <= 2'b00;
    end else begin
      h_clk <= HW'({h_clk, s_clk});
      h_hs  <= HW'({h_hs, s_hs});
      h_vs  <= HW'({h_vs, s_vs});
      if (clk_fall || clk_rise) f_clk <= s_clk;
      if (hs_fall || hs_rise)   f_hs  <= s_hs;
      if (vs_fall || vs_rise)   f_vs  <= s_vs;
      dhist[0] <= s_data;
      for (int i = 1; i < int'(DATA_DELAY); i++) dhist[i] <= dhist[i-1];
    end
  end

  logic [7:0]    x_q, y_q, x_d, y_d, px_x, px_y;
  logic          first_q, first_d, armed_q, armed_d, pix, in_range;
  logic [AW-1:0] px_addr;

  // Position tracking: vsync beats hsync beats pixel clock when events coincide.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    first_d  = first_q;
    armed_d  = armed_q;
    px_x     = x_q;
    px_y     = y_q;
    pix      = 1'b0;
    if (vs_rise) begin
      armed_d = 1'b1;
      x_d     = 8'd0;
      y_d     = 8'd0;
      first_d = 1'b1;
    end else if (armed_q && hs_fall) begin
      pix  = 1'b1;
      px_x = 8'd0;
      if (!first_q && (y_q < V_MAX)) px_y = y_q + 8'd1;
      y_d     = px_y;
      first_d = 1'b0;
    end else if (armed_q && clk_fall && !f_hs) begin
      pix = 1'b1;
    end
    px_addr  = AW'(px_y) * AW'(H_PIXELS) + AW'(px_x);
    in_range = (px_x < H_MAX) && (px_y < V_MAX);
    if (pix) x_d = (px_x < H_MAX) ? px_x + 8'd1 : H_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      first_q     <= 1'b1;
      armed_q     <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 2'b00;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      first_q     <= first_d;
      armed_q     <= armed_d;
      wr_en       <= pix && in_range;
      frame_start <= vs_rise;
      frame_done  <= pix && in_range && (px_addr == LAST_ADDR);
      line_err    <= pix && !in_range;
      if (pix && in_range) begin
        wr_addr <= px_addr;
        wr_data <= ~dhist[DATA_DELAY-1];
      end
    end
  end

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture: a default-geometry instance plus a short-frame (8-line) instance on the same bus.
module tb_gb_lcd_capture;

  localparam int unsigned FL = 4;
`ifdef GB_CAPTURE_SYNC_EN
  localparam int LAT = FL + 1;
`else
  localparam int LAT = FL - 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  idata;
  logic        ihsync, ivsync, iclk;
  logic        wr_en, frame_start, frame_done, line_err;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data;
  logic        sm_wr_en, sm_frame_start, sm_frame_done, sm_line_err;
  logic [14:0] sm_wr_addr;
  logic [1:0]  sm_wr_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  gb_lcd_capture #(.FILTER_LEN(FL), .DATA_DELAY(5), .H_PIXELS(160), .V_LINES(144)) u_dut (
    .clk(clk), .rst(rst), .idata(idata), .ihsync(ihsync), .ivsync(ivsync), .iclk(iclk),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .frame_done(frame_done), .line_err(line_err));

  gb_lcd_capture #(.FILTER_LEN(FL), .DATA_DELAY(5), .H_PIXELS(160), .V_LINES(8)) u_sm (
    .clk(clk), .rst(rst), .idata(idata), .ihsync(ihsync), .ivsync(ivsync), .iclk(iclk),
    .wr_en(sm_wr_en), .wr_addr(sm_wr_addr), .wr_data(sm_wr_data),
    .frame_start(sm_frame_start), .frame_done(sm_frame_done), .line_err(sm_line_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation on the falling edge, away from the active edge.
  logic [14:0] q_addr[$];
  logic [1:0]  q_data[$];
  int n_le, n_fs, n_fd, wr_cyc;
  int n_wr2, n_le2, n_fd2, fd_addr2;

  always @(negedge clk) begin
    if (wr_en) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      wr_cyc = cyc;
    end
    if (line_err)    n_le++;
    if (frame_start) n_fs++;
    if (frame_done)  n_fd++;
    if (sm_wr_en)    n_wr2++;
    if (sm_line_err) n_le2++;
    if (sm_frame_done) begin
      n_fd2++;
      fd_addr2 = sm_wr_en ? int'(sm_wr_addr) : -1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    q_addr.delete();
    q_data.delete();
    n_le = 0; n_fs = 0; n_fd = 0; wr_cyc = 0;
    n_wr2 = 0; n_le2 = 0; n_fd2 = 0; fd_addr2 = 0;
  endtask

  task automatic pulse(input logic [1:0] d);
    idata = d;
    iclk  = 1'b1;
    tick(5);
    iclk  = 1'b0;
    tick(5);
  endtask

  // One line: hsync fall carries pixel 0 with d0, then n-1 pixel-clock falls with d.
  task automatic line(input int n, input logic [1:0] d0, input logic [1:0] d);
    ihsync = 1'b1;
    idata  = d0;
    tick(10);
    ihsync = 1'b0;
    tick(10);
    for (int i = 1; i < n; i++) pulse(d);
  endtask

  task automatic vsync();
    ivsync = 1'b1;
    tick(10);
    ivsync = 1'b0;
    tick(10);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"},   int'(wr_en), 0);
    check({tag, "_wr_addr"}, int'(wr_addr), 0);
    check({tag, "_wr_data"}, int'(wr_data), 0);
    check({tag, "_fstart"},  int'(frame_start), 0);
    check({tag, "_fdone"},   int'(frame_done), 0);
    check({tag, "_lerr"},    int'(line_err), 0);
  endtask

  int t0;

  initial begin
    rst = 1'b1; idata = 2'b00; ihsync = 1'b1; ivsync = 1'b0; iclk = 1'b0;
    clear();
    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(2);

    // Not armed: hsync low and pixel clocks produce nothing.
    clear();
    ihsync = 1'b0;
    tick(10);
    for (int i = 0; i < 10; i++) pulse(2'b11);
    check("unarmed_wr", q_addr.size(), 0);
    check("unarmed_lerr", n_le, 0);
    check("unarmed_fs", n_fs, 0);

    // First line: pixel 0 from hsync (01 -> 10), pixels 1..159 from iclk (10 -> 01).
    clear();
    vsync();
    check("line0_fs", n_fs, 1);
    line(160, 2'b01, 2'b10);
    check("line0_nwr", q_addr.size(), 160);
    if (q_addr.size() == 160) begin
      check("line0_addr0", int'(q_addr[0]), 0);
      check("line0_data0", int'(q_data[0]), 2);
      for (int i = 1; i < 160; i++) begin
        check($sformatf("line0_addr%0d", i), int'(q_addr[i]), i);
        check($sformatf("line0_data%0d", i), int'(q_data[i]), 1);
      end
    end
    check("line0_lerr", n_le, 0);
    check("line0_fs_once", n_fs, 1);

    // Overlong line: 165 pixels -> 160 writes, 5 range errors; next line at 160.
    clear();
    vsync();
    line(165, 2'b11, 2'b00);
    check("ovf_nwr", q_addr.size(), 160);
    check("ovf_lerr", n_le, 5);
    if (q_addr.size() == 160) begin
      check("ovf_last_addr", int'(q_addr[159]), 159);
      check("ovf_data0", int'(q_data[0]), 0);
      check("ovf_data159", int'(q_data[159]), 3);
    end
    clear();
    line(3, 2'b00, 2'b00);
    check("next_nwr", q_addr.size(), 3);
    if (q_addr.size() == 3) begin
      check("next_addr0", int'(q_addr[0]), 160);
      check("next_addr2", int'(q_addr[2]), 162);
    end

    // Pixel-clock glitches: FL-1 low samples ignored, FL low samples write x=3.
    clear();
    idata = 2'b01;
    iclk  = 1'b1;
    tick(10);
    iclk  = 1'b0;
    tick(FL - 1);
    iclk  = 1'b1;
    tick(10);
    check("glitch_short_wr", q_addr.size(), 0);
    iclk = 1'b0;
    t0   = cyc + 1;
    tick(FL);
    iclk = 1'b1;
    tick(10);
    iclk = 1'b0;
    check("glitch_full_wr", q_addr.size(), 1);
    if (q_addr.size() == 1) begin
      check("glitch_addr", int'(q_addr[0]), 163);
      check("glitch_data", int'(q_data[0]), 2);
      check("glitch_latency", wr_cyc - t0, LAT);
    end
    tick(10);

    // Reset in the middle of line 50.
    clear();
    vsync();
    for (int l = 0; l < 50; l++) line(2, 2'b00, 2'b00);
    line(3, 2'b00, 2'b11);
    check("y50_nwr", q_addr.size(), 103);
    if (q_addr.size() == 103) check("y50_last_addr", int'(q_addr[102]), 8002);
    iclk = 1'b1;
    tick(5);
    iclk = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    check_outputs_zero("midrst");
    tick(2);
    rst = 1'b0;
    clear();
    tick(5);
    for (int i = 0; i < 3; i++) pulse(2'b10);
    line(2, 2'b00, 2'b00);
    check("postrst_wr", q_addr.size(), 0);
    check("postrst_lerr", n_le, 0);
    vsync();
    line(2, 2'b10, 2'b10);
    check("resume_nwr", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      check("resume_addr0", int'(q_addr[0]), 0);
      check("resume_addr1", int'(q_addr[1]), 1);
      check("resume_data", int'(q_data[1]), 1);
    end

    // Full 8-line frame on the short instance, then one surplus line.
    clear();
    vsync();
    for (int l = 0; l < 8; l++) line(160, 2'b00, 2'b11);
    check("frame_nwr", n_wr2, 1280);
    check("frame_fd_count", n_fd2, 1);
    check("frame_fd_addr", fd_addr2, 1279);
    check("frame_lerr", n_le2, 0);
    check("big_nwr", q_addr.size(), 1280);
    check("big_no_fd", n_fd, 0);
    line(160, 2'b00, 2'b11);
    check("surplus_nwr", n_wr2, 1280);
    check("surplus_lerr", n_le2, 160);
    check("big_surplus_nwr", q_addr.size(), 1440);
    if (q_addr.size() == 1440) check("big_surplus_last", int'(q_addr[1439]), 1439);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_lcd_capture.md
# gb_lcd_capture

Front-end decoder for the Game Boy LCD bus: it filters `iclk`, `ihsync` and `ivsync`, recovers pixel position, and emits one framebuffer write per captured pixel. It sits directly upstream of the framebuffer write port and VGA scan-out stage. Its writes go straight to that port, its `frame_start` pulse feeds the scan-out's missing-frame blanking logic, and it works entirely in the 40 MHz `pllclk` domain.

## Interface
- `FILTER_LEN`, 4: consecutive identical samples needed to change a filtered control state (2..8).
- `DATA_DELAY`, 5: how many cycles back `idata` is tapped relative to the edge-decision cycle (1..8).
- `H_PIXELS`, 160: pixels per line.
- `V_LINES`, 144: lines per frame.
- `clk` in 1: pixel-domain clock (`pllclk`); all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `idata` in 2: raw LCD pixel data, asynchronous.
- `ihsync` in 1: raw LCD hsync, asynchronous.
- `ivsync` in 1: raw LCD vsync, asynchronous.
- `iclk` in 1: raw LCD pixel clock, asynchronous.
- `wr_en` out 1: framebuffer write strobe, one cycle per pixel.
- `wr_addr` out 15: write address, `y*H_PIXELS + x`.
- `wr_data` out 2: pixel value, inverted GB data (`~idata`).
- `frame_start` out 1: one-cycle pulse on filtered `ivsync` rising edge.
- `frame_done` out 1: one-cycle pulse coincident with the write to the last address (23039).
- `line_err` out 1: one-cycle pulse when a pixel or line is dropped for being out of range.

## Operation
- Input path: raw inputs, optionally synchronized (see Configuration), feed per-signal histories. Filtered state `S` takes value `v` on the edge where the current sample and the previous `FILTER_LEN-1` samples all equal `v` and `S != v`. This produces a one-cycle edge event.
- Data history: a `DATA_DELAY`-deep shift of the same-path `idata`. Captured data is the tap from `DATA_DELAY` cycles before the decision edge, inverted.
- `armed` flag: reset 0. Set on the first filtered `ivsync` rise. While 0, no writes and no `line_err`.
- Filtered `ivsync` rise:
  - pulse `frame_start`;
  - set `armed`;
  - y := 0; x := 0; `first_line` := 1.
- Filtered `ihsync` fall, when armed:
  - if `first_line`=0, y := y+1; then `first_line` := 0;
  - write pixel x=0; x := 1.
- Filtered `iclk` fall while filtered `ihsync`=0 and armed: write pixel x; x := x+1.
- Simultaneous `ihsync` fall and `iclk` fall: the hsync action wins and exactly one write occurs.
- Simultaneous `ivsync` rise and any pixel event: the vsync action wins and no write occurs that cycle.
- Range check: a pixel with x ≥ `H_PIXELS` or y ≥ `V_LINES` is not written. It pulses `line_err` instead, and x saturates at `H_PIXELS`. y saturates at `V_LINES`.
- Counters: x is 8 bits and y is 8 bits. The address is computed as `y*160+x` in 15 bits and is always < 23040 when `wr_en`=1.
- `frame_done` asserts with `wr_en` when `wr_addr` = `H_PIXELS*V_LINES-1`.
- Reset values:
  - all outputs 0;
  - filtered `iclk`=0, `ihsync`=1, `ivsync`=0;
  - histories cleared to those same levels;
  - x=y=0, `first_line`=1, `armed`=0.
- Reset mid-line drops all in-progress state. Capture resumes only after the next `ivsync` rise.

## Timing
- A raw level first sampled at edge k produces a filtered change, and any resulting registered output, at edge k+`FILTER_LEN`-1. Add +2 edges with the synchronizer enabled.
- `wr_en`, `wr_addr`, `wr_data`, `frame_done` and `line_err` are registered and valid for exactly one cycle. No back-pressure: the framebuffer accepts every cycle.
- Minimum spacing of pixel events is `2*FILTER_LEN` cycles. This is guaranteed by the GB pixel clock of about 4 MHz against the 40 MHz `clk`.
- Glitches shorter than `FILTER_LEN` samples cause no state change and no write.

## Configuration
- `GB_CAPTURE_SYNC_EN` defined:
  - all four raw inputs pass through a 2-flop synchronizer before filtering and data history;
  - latency is +2 cycles;
  - relative data alignment is unchanged.
- `GB_CAPTURE_SYNC_EN` undefined: raw inputs feed the filter and history directly, matching the legacy capture timing.

## Test plan
- No `ivsync` after reset, `ihsync` held low and 10 `iclk` pulses → `wr_en` never asserts and `line_err` stays 0.
- `ivsync` rise, then hsync fall with `idata`=2'b01, then 159 `iclk` falls with `idata`=2'b10 → 160 writes; addr 0 data 2'b10, addrs 1..159 data 2'b01, one `frame_start`.
- A full 144-line frame → last write at addr 23039 with `frame_done`=1 on the same cycle, and exactly 23040 `wr_en` pulses.
- 165 pixels on one line → 160 writes and 5 `line_err` pulses; the next line starts at addr 160.
- `iclk` low glitch of `FILTER_LEN`-1 cycles mid-line → no write. The glitch at exactly `FILTER_LEN` cycles → one write, `FILTER_LEN`-1 edges after the first low sample (+2 with sync).
- `rst` asserted mid-line at y=50 → outputs 0 next edge. Writes resume at addr 0 only after the next `ivsync` rise.
